// File: rtl/muln_pkg.sv
// Shared types and helpers for the streaming multiple-of-N checker.
package muln_pkg;

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } state_e;

  localparam int unsigned LEN_W = 16;

  // Narrowest width that holds every remainder 0..n-1.
  function automatic int unsigned rem_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muln_digit_step.sv
// Combinational (rem, digit) -> (rem * 2^DIGIT_W + digit) mod N, one conditional
// subtract per digit bit, MSB first.
module muln_digit_step
  import muln_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned DIGIT_W = 1,
  parameter int unsigned REM_W   = rem_width(N)
) (
  input  logic [REM_W-1:0]   rem,
  input  logic [DIGIT_W-1:0] digit,
  output logic [REM_W-1:0]   rem_next
);

  localparam logic [REM_W:0] NVal = (REM_W + 1)'(N);

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
    logic [REM_W-1:0] r_in;
    logic [REM_W-1:0] r_out;
    logic [REM_W:0]   dbl;

    if (i == 0) begin : g_first
      assign r_in = rem;
    end else begin : g_chain
      assign r_in = g_bit[i-1].r_out;
    end

    // r_in < N, so 2*r_in + b < 2N and a single subtract restores the range.
    assign dbl   = {r_in, digit[DIGIT_W-1-i]};
    assign r_out = (dbl >= NVal) ? REM_W'(dbl - NVal) : REM_W'(dbl);
  end

  assign rem_next = g_bit[DIGIT_W-1].r_out;

endmodule

// File: rtl/muln_stream_checker.sv
// Streaming multiple-of-N checker over MSB-first digit beats with a registered result.
// Defining MULN_LEN_CNT_EN adds the m_len output (beats in the reported frame).
module muln_stream_checker
  import muln_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned DIGIT_W = 1,
  parameter int unsigned REM_W   = rem_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DIGIT_W-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [REM_W-1:0]   m_rem,
  output logic               m_is_mult
`ifdef MULN_LEN_CNT_EN
  ,
  output logic [LEN_W-1:0]   m_len
`endif
);

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d, rem_next;
  logic [REM_W-1:0] m_rem_q, m_rem_d;
  logic             m_is_mult_q, m_is_mult_d;
  logic             beat_acc;

  muln_digit_step #(
    .N       (N),
    .DIGIT_W (DIGIT_W),
    .REM_W   (REM_W)
  ) u_step (
    .rem      (rem_q),
    .digit    (s_data),
    .rem_next (rem_next)
  );

  // clear wins over acceptance, including on the s_last beat.
  assign beat_acc = (state_q == StAccum) && s_valid && !clear;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    m_rem_d     = m_rem_q;
    m_is_mult_d = m_is_mult_q;
    case (state_q)
      StAccum: begin
        if (clear) begin
          rem_d = '0;
        end else if (beat_acc) begin
          if (s_last) begin
            m_rem_d     = rem_next;
            m_is_mult_d = (rem_next == '0);
            rem_d       = '0;
            state_d     = StHold;
          end else begin
            rem_d = rem_next;
          end
        end
      end
      StHold: begin
        if (clear || m_ready) state_d = StAccum;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      rem_q       <= '0;
      m_rem_q     <= '0;
      m_is_mult_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      m_rem_q     <= m_rem_d;
      m_is_mult_q <= m_is_mult_d;
    end
  end

  assign s_ready   = (state_q == StAccum);
  assign m_valid   = (state_q == StHold);
  assign m_rem     = m_rem_q;
  assign m_is_mult = m_is_mult_q;

`ifdef MULN_LEN_CNT_EN
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic [LEN_W-1:0] m_len_q, m_len_d;

  // Saturating count; len_inc already includes the beat being accepted.
  assign len_inc = (len_q == '1) ? len_q : len_q + 1'b1;

  always_comb begin
    len_d   = len_q;
    m_len_d = m_len_q;
    if (state_q == StAccum && clear) begin
      len_d = '0;
    end else if (beat_acc) begin
      if (s_last) begin
        m_len_d = len_inc;
        len_d   = '0;
      end else begin
        len_d = len_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      m_len_q <= '0;
    end else begin
      len_q   <= len_d;
      m_len_q <= m_len_d;
    end
  end

  assign m_len = m_len_q;
`endif

endmodule

// File: tb/tb_muln_stream_checker.sv
// Bench for muln_stream_checker: directed checks on N=3/D=1 and N=5/D=8 instances,
// scoreboarded random frames on an N=7/D=4 instance.
module tb_muln_stream_checker;
  import muln_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Instance A: N=3, DIGIT_W=1
  logic       a_clear, a_s_valid, a_s_ready, a_s_data, a_s_last;
  logic       a_m_valid, a_m_ready, a_m_is_mult;
  logic [1:0] a_m_rem;
  // Instance B: N=7, DIGIT_W=4
  logic       b_clear, b_s_valid, b_s_ready, b_s_last;
  logic       b_m_valid, b_m_ready, b_m_is_mult;
  logic [3:0] b_s_data;
  logic [2:0] b_m_rem;
  // Instance C: N=5, DIGIT_W=8
  logic       c_clear, c_s_valid, c_s_ready, c_s_last;
  logic       c_m_valid, c_m_ready, c_m_is_mult;
  logic [7:0] c_s_data;
  logic [2:0] c_m_rem;
`ifdef MULN_LEN_CNT_EN
  logic [LEN_W-1:0] a_m_len, b_m_len, c_m_len;
`endif

  muln_stream_checker #(.N(3), .DIGIT_W(1)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (a_clear),
    .s_valid   (a_s_valid),
    .s_ready   (a_s_ready),
    .s_data    (a_s_data),
    .s_last    (a_s_last),
    .m_valid   (a_m_valid),
    .m_ready   (a_m_ready),
    .m_rem     (a_m_rem),
    .m_is_mult (a_m_is_mult)
`ifdef MULN_LEN_CNT_EN
    ,
    .m_len     (a_m_len)
`endif
  );

  muln_stream_checker #(.N(7), .DIGIT_W(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (b_clear),
    .s_valid   (b_s_valid),
    .s_ready   (b_s_ready),
    .s_data    (b_s_data),
    .s_last    (b_s_last),
    .m_valid   (b_m_valid),
    .m_ready   (b_m_ready),
    .m_rem     (b_m_rem),
    .m_is_mult (b_m_is_mult)
`ifdef MULN_LEN_CNT_EN
    ,
    .m_len     (b_m_len)
`endif
  );

  muln_stream_checker #(.N(5), .DIGIT_W(8)) u_dut_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (c_clear),
    .s_valid   (c_s_valid),
    .s_ready   (c_s_ready),
    .s_data    (c_s_data),
    .s_last    (c_s_last),
    .m_valid   (c_m_valid),
    .m_ready   (c_m_ready),
    .m_rem     (c_m_rem),
    .m_is_mult (c_m_is_mult)
`ifdef MULN_LEN_CNT_EN
    ,
    .m_len     (c_m_len)
`endif
  );

  typedef struct packed {
    logic [2:0]  rem;
    logic [15:0] len;
  } b_exp_t;

  b_exp_t b_q[$];
  logic   b_stop = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic a_send(input logic d, input logic last);
    a_s_valid = 1'b1;
    a_s_data  = d;
    a_s_last  = last;
    for (int i = 0; i < 50 && !a_s_ready; i++) @(negedge clk);
    check_eq("a_s_ready_before_beat", a_s_ready, 1);
    @(negedge clk);
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
  endtask

  task automatic b_beat(input logic [3:0] d, input logic last, input logic gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      b_s_valid = 1'b0;
      @(negedge clk);
    end
    b_s_valid = 1'b1;
    b_s_data  = d;
    b_s_last  = last;
    for (int i = 0; i < 1000 && !b_s_ready; i++) @(negedge clk);
    if (!b_s_ready) check_eq("b_accept_timeout", b_s_ready, 1);
    @(negedge clk);
    b_s_valid = 1'b0;
  endtask

  // kind 0: all 0xF, kind 1: 1,2,3..., otherwise random digits.
  task automatic b_frame(input int unsigned n_beats, input int unsigned kind, input logic gaps);
    int unsigned r;
    logic [3:0]  d;
    b_exp_t      e;
    r = 0;
    for (int unsigned i = 0; i < n_beats; i++) begin
      if (kind == 0) d = 4'hF;
      else if (kind == 1) d = 4'(i + 1);
      else d = 4'($urandom);
      r = (r * 16 + d) % 7;
      if (i == n_beats - 1) begin
        e.rem = 3'(r);
        e.len = 16'((n_beats > 65535) ? 65535 : n_beats);
        b_q.push_back(e);
      end
      b_beat(d, i == n_beats - 1, gaps);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    b_exp_t e;
    rst_n = 1'b0;
    {a_clear, a_s_valid, a_s_data, a_s_last, a_m_ready} = '0;
    {b_clear, b_s_valid, b_s_data, b_s_last, b_m_ready} = '0;
    {c_clear, c_s_valid, c_s_data, c_s_last, c_m_ready} = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_a_s_ready", a_s_ready, 1);
    check_eq("rst_a_m_valid", a_m_valid, 0);
    check_eq("rst_a_m_rem", a_m_rem, 0);
    check_eq("rst_a_m_is_mult", a_m_is_mult, 0);
    check_eq("rst_b_m_valid", b_m_valid, 0);
    check_eq("rst_c_s_ready", c_s_ready, 1);
`ifdef MULN_LEN_CNT_EN
    check_eq("rst_a_m_len", a_m_len, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 110b = 6 -> multiple of 3, result one cycle after the last beat
    a_send(1'b1, 1'b0);
    a_send(1'b1, 1'b0);
    check_eq("a_no_early_valid", a_m_valid, 0);
    a_send(1'b0, 1'b1);
    check_eq("a_latency_valid", a_m_valid, 1);
    check_eq("a_rem_110", a_m_rem, 0);
    check_eq("a_mult_110", a_m_is_mult, 1);
    check_eq("a_hold_s_ready", a_s_ready, 0);
`ifdef MULN_LEN_CNT_EN
    check_eq("a_len_3", a_m_len, 3);
`endif
    a_m_ready = 1'b1;
    @(negedge clk);
    a_m_ready = 1'b0;
    check_eq("a_after_hs_valid", a_m_valid, 0);
    check_eq("a_after_hs_ready", a_s_ready, 1);

    // Backpressure: 10b = 2 held for 5 cycles
    a_send(1'b1, 1'b0);
    a_send(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("a_bp_s_ready", a_s_ready, 0);
      check_eq("a_bp_m_valid", a_m_valid, 1);
      check_eq("a_bp_m_rem", a_m_rem, 2);
      check_eq("a_bp_is_mult", a_m_is_mult, 0);
      @(negedge clk);
    end
    a_m_ready = 1'b1;
    @(negedge clk);
    a_m_ready = 1'b0;
    check_eq("a_bp_release_ready", a_s_ready, 1);
    check_eq("a_bp_release_valid", a_m_valid, 0);

    // clear on the s_last beat drops the frame
    a_send(1'b1, 1'b0);
    a_s_valid = 1'b1;
    a_s_data  = 1'b1;
    a_s_last  = 1'b1;
    a_clear   = 1'b1;
    @(negedge clk);
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
    a_clear   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("a_clear_no_result", a_m_valid, 0);
      @(negedge clk);
    end
    a_send(1'b1, 1'b0);
    a_send(1'b1, 1'b1);
    check_eq("a_after_clear_valid", a_m_valid, 1);
    check_eq("a_after_clear_rem", a_m_rem, 0);
    check_eq("a_after_clear_mult", a_m_is_mult, 1);

    // clear in HOLD drops the pending result
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    check_eq("a_clear_hold_valid", a_m_valid, 0);
    check_eq("a_clear_hold_ready", a_s_ready, 1);

    // Reset mid-frame: immediate effect, next frame starts from rem=0
    a_send(1'b1, 1'b0);
    a_send(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("a_rst_mid_valid", a_m_valid, 0);
    check_eq("a_rst_mid_ready", a_s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    a_send(1'b1, 1'b1);
    check_eq("a_post_rst_rem", a_m_rem, 1);
    check_eq("a_post_rst_mult", a_m_is_mult, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("a_rst_hold_valid", a_m_valid, 0);
    check_eq("a_rst_hold_rem", a_m_rem, 0);
    check_eq("a_rst_hold_ready", a_s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // N=5, 8-bit digits: 0xFF -> 0, then 0x07 -> 2
    c_s_valid = 1'b1;
    c_s_data  = 8'hFF;
    c_s_last  = 1'b1;
    @(negedge clk);
    c_s_valid = 1'b0;
    check_eq("c_ff_valid", c_m_valid, 1);
    check_eq("c_ff_rem", c_m_rem, 0);
    check_eq("c_ff_mult", c_m_is_mult, 1);
    c_m_ready = 1'b1;
    @(negedge clk);
    c_m_ready = 1'b0;
    check_eq("c_hs_ready", c_s_ready, 1);
    c_s_valid = 1'b1;
    c_s_data  = 8'h07;
    @(negedge clk);
    c_s_valid = 1'b0;
    check_eq("c_07_valid", c_m_valid, 1);
    check_eq("c_07_rem", c_m_rem, 2);
    check_eq("c_07_mult", c_m_is_mult, 0);
`ifdef MULN_LEN_CNT_EN
    check_eq("c_07_len", c_m_len, 1);
`endif

    // N=7, 4-bit digits: scoreboarded frames with random output backpressure
    fork
      begin : b_driver
        b_frame(2, 0, 1'b0);
        b_frame(3, 1, 1'b1);
        for (int f = 0; f < 250; f++) b_frame($urandom_range(1, 64), 2, 1'b1);
`ifdef MULN_LEN_CNT_EN
        b_frame(70000, 2, 1'b0);
`endif
        for (int i = 0; i < 1000 && b_q.size() != 0; i++) @(negedge clk);
        check_eq("b_drained", b_q.size(), 0);
        b_stop = 1'b1;
      end
      begin : b_monitor
        while (!b_stop) begin
          @(negedge clk);
          b_m_ready = ($urandom_range(0, 1) == 1);
          if (b_m_valid) check_eq("b_hold_s_ready", b_s_ready, 0);
          if (b_m_valid && b_m_ready) begin
            check_eq("b_sb_empty", b_q.size() == 0, 0);
            if (b_q.size() != 0) begin
              e = b_q.pop_front();
              check_eq("b_rem", b_m_rem, e.rem);
              check_eq("b_is_mult", b_m_is_mult, e.rem == 3'd0);
`ifdef MULN_LEN_CNT_EN
              check_eq("b_len", b_m_len, e.len);
`endif
            end
          end
        end
      end
    join
    b_m_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
